// File: rtl/rattlesnake_fetch_pkg.sv
// Shared types and constants for the Rattlesnake instruction prefetch unit.
package rattlesnake_fetch_pkg;

  localparam logic [1:0] RV_OPCODE_32 = 2'b11;
  localparam int         WORD_W       = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
  } fetch_word_t;

endpackage

// File: rtl/rattlesnake_fetch_word_queue.sv
// Synchronous word FIFO with flush, occupancy count and a two-entry head peek
// so that instructions straddling a word boundary can be assembled.
module rattlesnake_fetch_word_queue
  import rattlesnake_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_word_t              push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_word_t              head0_o,
  output fetch_word_t              head1_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_word_t       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q;
  logic [PTR_W-1:0]  rd_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage carries no reset; occupancy alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[rd_q + PTR_W'(1)];

endmodule

// File: rtl/rattlesnake_prefetch_fetch.sv
// Rattlesnake prefetch unit: keeps aligned words in flight or buffered and
// extracts RV32IC instructions (including word-straddling ones) for decode.
module rattlesnake_prefetch_fetch
  import rattlesnake_fetch_pkg::*;
#(
  parameter int PC_BITWIDTH     = 32,
  parameter int XLEN            = 32,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   fetch_init,
  input  logic [PC_BITWIDTH-1:0] start_addr,
  input  logic                   fetch_next,
  output logic                   fetch_enable_out,
  output logic [XLEN-1:0]        IR_out,
  output logic                   is_c_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   read_mem_enable,
  output logic [PC_BITWIDTH-1:0] read_mem_addr,
  input  logic                   mem_read_done,
  input  logic [XLEN-1:0]        mem_data
);

  localparam int               CNT_W     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QUEUE_DEPTH);

  fetch_state_e           state_q, state_d;
  logic [CNT_W-1:0]       live_q, live_d, stale_q, stale_d;
  logic [PC_BITWIDTH-1:0] fetch_ptr_q, fetch_ptr_d, ex_pc_q, ex_pc_d;
  logic                   hw_sel_q, hw_sel_d;
  logic                   fen_q, fen_d, is_c_q, is_c_d, rd_en_q, rd_en_d;
  logic [XLEN-1:0]        ir_q, ir_d;
  logic [PC_BITWIDTH-1:0] pc_q, pc_d, rd_addr_q, rd_addr_d;

  logic             flush, resp_live, push, pop, load, issue;
  logic             ext_ok, ext_c, ext_pop, ext_hw;
  logic [XLEN-1:0]  ext_ir;
  logic [CNT_W-1:0] q_count;
  fetch_word_t      w0, w1, push_word;
  logic             unused_bits;

  assign push_word.data = mem_data;
  assign unused_bits    = ^{start_addr[0], w1.data[31:16]};

  rattlesnake_fetch_word_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (reset_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (pop),
    .count_o     (q_count),
    .head0_o     (w0),
    .head1_o     (w1)
  );

  always_comb begin
    flush     = fetch_init | sync_reset;
    resp_live = mem_read_done && (stale_q == '0);
    push      = resp_live && !flush;

    ext_ok  = 1'b0;
    ext_c   = 1'b0;
    ext_pop = 1'b0;
    ext_hw  = hw_sel_q;
    ext_ir  = '0;
    if (q_count != '0) begin
      if (!hw_sel_q) begin
        ext_ok = 1'b1;
        if (w0.data[1:0] == RV_OPCODE_32) begin
          ext_ir  = w0.data;
          ext_pop = 1'b1;
        end else begin
          ext_ir = {16'h0000, w0.data[15:0]};
          ext_c  = 1'b1;
          ext_hw = 1'b1;
        end
      end else if (w0.data[17:16] != RV_OPCODE_32) begin
        ext_ok  = 1'b1;
        ext_ir  = {16'h0000, w0.data[31:16]};
        ext_c   = 1'b1;
        ext_hw  = 1'b0;
        ext_pop = 1'b1;
      end else if (q_count >= CNT_W'(2)) begin
        // Upper half of w0 starts a 32-bit instruction finished by w1.
        ext_ok  = 1'b1;
        ext_ir  = {w1.data[15:0], w0.data[31:16]};
        ext_pop = 1'b1;
      end
    end

    load  = ext_ok && (!fen_q || fetch_next) && !flush;
    pop   = load && ext_pop;
    issue = (state_q == ST_RUN) && !flush &&
            ((live_q + stale_q) < MAX_OUT_C) &&
            ((live_q + q_count) < DEPTH_C);

    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    ex_pc_d     = ex_pc_q;
    hw_sel_d    = hw_sel_q;
    fen_d       = fen_q;
    ir_d        = ir_q;
    is_c_d      = is_c_q;
    pc_d        = pc_q;
    rd_en_d     = issue;
    rd_addr_d   = rd_addr_q;
    live_d      = live_q + CNT_W'(issue) - CNT_W'(resp_live);
    stale_d     = stale_q - CNT_W'(mem_read_done && !resp_live);

    if (issue) begin
      rd_addr_d   = fetch_ptr_q;
      fetch_ptr_d = fetch_ptr_q + PC_BITWIDTH'(4);
    end

    if (load) begin
      ir_d     = ext_ir;
      is_c_d   = ext_c;
      pc_d     = ex_pc_q;
      ex_pc_d  = ex_pc_q + (ext_c ? PC_BITWIDTH'(2) : PC_BITWIDTH'(4));
      hw_sel_d = ext_hw;
      fen_d    = 1'b1;
    end else if (fetch_next) begin
      fen_d = 1'b0;
    end

    // A flush turns every request still in flight into one to be discarded.
    if (flush) begin
      state_d     = sync_reset ? ST_IDLE : ST_RUN;
      fen_d       = 1'b0;
      fetch_ptr_d = {start_addr[PC_BITWIDTH-1:2], 2'b00};
      ex_pc_d     = {start_addr[PC_BITWIDTH-1:1], 1'b0};
      hw_sel_d    = start_addr[1];
      stale_d     = live_q + stale_q - CNT_W'(mem_read_done);
      live_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      live_q      <= '0;
      stale_q     <= '0;
      fetch_ptr_q <= '0;
      ex_pc_q     <= '0;
      hw_sel_q    <= 1'b0;
      fen_q       <= 1'b0;
      ir_q        <= '0;
      is_c_q      <= 1'b0;
      pc_q        <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      stale_q     <= stale_d;
      fetch_ptr_q <= fetch_ptr_d;
      ex_pc_q     <= ex_pc_d;
      hw_sel_q    <= hw_sel_d;
      fen_q       <= fen_d;
      ir_q        <= ir_d;
      is_c_q      <= is_c_d;
      pc_q        <= pc_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign fetch_enable_out = fen_q;
  assign IR_out           = ir_q;
  assign is_c_out         = is_c_q;
  assign PC_out           = pc_q;
  assign read_mem_enable  = rd_en_q;
  assign read_mem_addr    = rd_addr_q;

endmodule

// File: tb/tb_rattlesnake_prefetch_fetch.sv
// Directed bench for the prefetch unit: in-order memory responder plus
// hand-computed instruction streams checked with immediate assertions.
module tb_rattlesnake_prefetch_fetch;

  logic        clk = 1'b0;
  logic        reset_n, sync_reset, fetch_init, fetch_next;
  logic [31:0] start_addr;
  logic        fetch_enable_out, is_c_out, read_mem_enable, mem_read_done;
  logic [31:0] IR_out, PC_out, read_mem_addr, mem_data;

  int total = 0;
  int bad   = 0;
  int waited;
  int req_cnt = 0;
  int req_mark;
  logic        mem_en = 1'b1;
  logic [31:0] pend [$];
  logic [31:0] memory [logic [31:0]];

  always #5 clk = ~clk;

  rattlesnake_prefetch_fetch dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sync_reset       (sync_reset),
    .fetch_init       (fetch_init),
    .start_addr       (start_addr),
    .fetch_next       (fetch_next),
    .fetch_enable_out (fetch_enable_out),
    .IR_out           (IR_out),
    .is_c_out         (is_c_out),
    .PC_out           (PC_out),
    .read_mem_enable  (read_mem_enable),
    .read_mem_addr    (read_mem_addr),
    .mem_read_done    (mem_read_done),
    .mem_data         (mem_data)
  );

  // Unlisted words hold a 32-bit instruction whose upper bits echo the address.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (memory.exists(a)) return memory[a];
    return {a[31:2], 2'b11};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_read_done = 1'b0;
    if (read_mem_enable) begin
      pend.push_back(read_mem_addr);
      req_cnt++;
    end
    if (mem_en && pend.size() > 0) begin
      mem_read_done = 1'b1;
      mem_data      = mem_word(pend.pop_front());
    end
  endtask

  task automatic expect_instr(string tag, logic [31:0] pc, logic [31:0] ir, logic c);
    waited = 0;
    while (!fetch_enable_out && waited < 30) begin
      step();
      waited++;
    end
    chk({tag, "_vld"}, 32'(fetch_enable_out), 32'd1);
    chk({tag, "_pc"}, PC_out, pc);
    chk({tag, "_ir"}, IR_out, ir);
    chk({tag, "_c"}, 32'(is_c_out), 32'(c));
    step();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_fen"}, 32'(fetch_enable_out), 32'd0);
    chk({tag, "_ir"}, IR_out, 32'd0);
    chk({tag, "_c"}, 32'(is_c_out), 32'd0);
    chk({tag, "_pc"}, PC_out, 32'd0);
    chk({tag, "_ren"}, 32'(read_mem_enable), 32'd0);
    chk({tag, "_raddr"}, read_mem_addr, 32'd0);
  endtask

  task automatic redirect(logic [31:0] a);
    start_addr = a;
    fetch_init = 1'b1;
    step();
    fetch_init = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    sync_reset    = 1'b0;
    fetch_init    = 1'b0;
    fetch_next    = 1'b0;
    start_addr    = '0;
    mem_read_done = 1'b0;
    mem_data      = '0;
    memory[32'h0]   = 32'h0513_4501;
    memory[32'h4]   = 32'h8082_0000;
    memory[32'h200] = 32'h1234_0203;

    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step();
    chk("idle_noreq", 32'(req_cnt), 32'd0);

    // Aligned 32-bit stream at 0x100, one-cycle memory
    fetch_next = 1'b1;
    redirect(32'h100);
    chk("first_req_lo", 32'(read_mem_enable), 32'd0);
    step();
    chk("first_req", 32'(read_mem_enable), 32'd1);
    chk("first_addr", read_mem_addr, 32'h100);
    expect_instr("a0", 32'h100, 32'h103, 1'b0);
    chk("fill_lat", 32'(waited), 32'd2);
    expect_instr("a1", 32'h104, 32'h107, 1'b0);
    expect_instr("a2", 32'h108, 32'h10b, 1'b0);
    chk("tput2", 32'(waited), 32'd0);
    expect_instr("a3", 32'h10c, 32'h10f, 1'b0);
    chk("tput3", 32'(waited), 32'd0);

    // Mixed C / straddling 32-bit at 0x0, second word held back
    redirect(32'h0);
    step();
    mem_en = 1'b0;
    expect_instr("m0", 32'h0, 32'h0000_4501, 1'b1);
    repeat (3) step();
    chk("straddle_wait", 32'(fetch_enable_out), 32'd0);
    mem_en = 1'b1;
    expect_instr("m1", 32'h2, 32'h0000_0513, 1'b0);
    expect_instr("m2", 32'h6, 32'h0000_8082, 1'b1);
    expect_instr("m3", 32'h8, 32'h0000_000b, 1'b0);

    // Odd start address
    redirect(32'h202);
    step();
    chk("odd_req", 32'(read_mem_enable), 32'd1);
    chk("odd_addr", read_mem_addr, 32'h200);
    expect_instr("o0", 32'h202, 32'h0000_1234, 1'b1);
    expect_instr("o1", 32'h204, 32'h207, 1'b0);

    // Redirect with two requests stuck in flight
    mem_en = 1'b0;
    repeat (4) step();
    chk("inflight", 32'(pend.size()), 32'd2);
    redirect(32'h400);
    chk("redir_flush", 32'(fetch_enable_out), 32'd0);
    mem_en = 1'b1;
    expect_instr("r0", 32'h400, 32'h403, 1'b0);
    expect_instr("r1", 32'h404, 32'h407, 1'b0);

    // Backpressure for 10 cycles
    fetch_next = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) req_mark = req_cnt;
      step();
    end
    chk("bp_vld", 32'(fetch_enable_out), 32'd1);
    chk("bp_pc", PC_out, 32'h408);
    chk("bp_ir", IR_out, 32'h40b);
    chk("bp_noreq", 32'(req_cnt - req_mark), 32'd0);
    chk("bp_lastaddr", read_mem_addr, 32'h418);
    fetch_next = 1'b1;
    expect_instr("b0", 32'h408, 32'h40b, 1'b0);
    expect_instr("b1", 32'h40c, 32'h40f, 1'b0);
    chk("bp_tput", 32'(waited), 32'd0);
    expect_instr("b2", 32'h410, 32'h413, 1'b0);

    // Synchronous flush to IDLE
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    chk("sr_fen", 32'(fetch_enable_out), 32'd0);
    req_mark = req_cnt;
    repeat (5) step();
    chk("sr_noreq", 32'(req_cnt - req_mark), 32'd0);
    chk("sr_fen2", 32'(fetch_enable_out), 32'd0);

    // Asynchronous reset in the middle of a stream
    redirect(32'h100);
    expect_instr("s0", 32'h100, 32'h103, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    pend.delete();
    mem_read_done = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    req_mark = req_cnt;
    repeat (6) step();
    chk("arst_noreq", 32'(req_cnt - req_mark), 32'd0);
    chk("arst_fen", 32'(fetch_enable_out), 32'd0);
    redirect(32'h100);
    expect_instr("t0", 32'h100, 32'h103, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
